// File: rtl/imuldiv_int_div_iterative_param_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// fn field encoding carried on the divide request.
package imuldiv_int_div_iterative_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic FN_SIGNED   = 1'b1;
  localparam logic FN_UNSIGNED = 1'b0;

endpackage

// File: rtl/imuldiv_int_div_iterative_param_if.sv
// Divide request/response val/rdy bundle.
//   divreq_*  : request (fn, dividend a, divisor b, val/rdy)
//   divresp_* : response ({remainder, quotient}, val/rdy)
// master = requester, slave = divider.
interface imuldiv_int_div_iterative_param_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 divreq_msg_fn;
  logic [WIDTH-1:0]     divreq_msg_a;
  logic [WIDTH-1:0]     divreq_msg_b;
  logic                 divreq_val;
  logic                 divreq_rdy;
  logic [2*WIDTH-1:0]   divresp_msg_result;
  logic                 divresp_val;
  logic                 divresp_rdy;

  modport master (
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    input  divreq_rdy, divresp_msg_result, divresp_val
  );

  modport slave (
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val, divresp_rdy,
    output divreq_rdy, divresp_msg_result, divresp_val
  );
endinterface

// File: rtl/imuldiv_DivLzc.sv
// Combinational leading-zero counter used by the divider early-out.
//   x  : operand
//   lz : number of leading zeros of x (WIDTH when x == 0)
// Only built when IMULDIV_DIV_EARLY_OUT_EN is defined.
`ifdef IMULDIV_DIV_EARLY_OUT_EN
module imuldiv_DivLzc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] x,
  output logic [CNT_W-1:0] lz
);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    lz = CNT_W'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (x[i]) lz = CNT_W'(int'(WIDTH) - 1 - i);
    end
  end

endmodule
`endif

// File: rtl/imuldiv_int_div_iterative_param.sv
// Width-generic restoring iterative divider, one quotient bit per cycle.
// Signed/unsigned, RISC-V divide-by-zero and overflow results resolved at
// load, back-to-back acceptance in the response cycle.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : divide request/response bundle (slave side)
// Build option: IMULDIV_DIV_EARLY_OUT_EN enables the leading-zero early-out.
module imuldiv_int_div_iterative_param
  import imuldiv_int_div_iterative_param_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  imuldiv_int_div_iterative_param_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned AW    = 2 * WIDTH + 1;

  div_state_e           state, state_d;
  logic [CNT_W-1:0]     cnt;
  logic [AW-1:0]        a_reg, b_reg;
  logic                 sign_q, sign_r;
  logic [2*WIDTH-1:0]   result;

  logic                 load, req_rdy, resp_val, step_last;
  logic                 is_signed, a_neg, b_neg;
  logic                 div_zero, sgn_ovf, special;
  logic [WIDTH-1:0]     op_a, op_b, min_neg;
  logic [AW-1:0]        a_init, shifted, diff, a_step;
  logic [CNT_W-1:0]     cnt_init;
  logic [WIDTH-1:0]     rem_raw, quo_raw;
  logic [2*WIDTH-1:0]   special_res, calc_res;

  // Operand conditioning at load
  assign is_signed = (bus.divreq_msg_fn == FN_SIGNED);
  assign a_neg     = is_signed & bus.divreq_msg_a[WIDTH-1];
  assign b_neg     = is_signed & bus.divreq_msg_b[WIDTH-1];
  assign op_a      = a_neg ? WIDTH'(-bus.divreq_msg_a) : bus.divreq_msg_a;
  assign op_b      = b_neg ? WIDTH'(-bus.divreq_msg_b) : bus.divreq_msg_b;
  assign min_neg   = {1'b1, {(WIDTH-1){1'b0}}};
  assign div_zero  = (bus.divreq_msg_b == '0);
  assign sgn_ovf   = is_signed && (bus.divreq_msg_a == min_neg) && (bus.divreq_msg_b == '1);

`ifdef IMULDIV_DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;

  imuldiv_DivLzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc (
    .x  (op_a),
    .lz (lz)
  );

  // Pre-normalise the dividend so only its significant bits are iterated.
  assign special  = div_zero | sgn_ovf | (op_a == '0);
  assign a_init   = {(WIDTH+1)'(0), op_a << lz};
  assign cnt_init = CNT_W'(WIDTH) - lz;
`else
  assign special  = div_zero | sgn_ovf;
  assign a_init   = {(WIDTH+1)'(0), op_a};
  assign cnt_init = CNT_W'(WIDTH);
`endif

  // Results that bypass iteration (zero dividend with early-out yields 0)
  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = {bus.divreq_msg_a, {WIDTH{1'b1}}};
    else if (sgn_ovf) special_res = {{WIDTH{1'b0}}, min_neg};
  end

  // One restoring step; diff[0] is always 0 so OR-ing in the quotient bit is exact
  assign shifted   = a_reg << 1;
  assign diff      = shifted - b_reg;
  assign a_step    = diff[AW-1] ? shifted : (diff | AW'(1));
  assign rem_raw   = a_step[2*WIDTH-1:WIDTH];
  assign quo_raw   = a_step[WIDTH-1:0];
  assign calc_res  = {sign_r ? WIDTH'(-rem_raw) : rem_raw,
                      sign_q ? WIDTH'(-quo_raw) : quo_raw};
  assign step_last = (cnt == CNT_W'(1));

  // Control FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Control FSM next state and handshake
  always_comb begin
    state_d  = state;
    load     = 1'b0;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (bus.divreq_val) begin
          load    = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (step_last) state_d = DONE;
      end
      DONE: begin
        resp_val = 1'b1;
        req_rdy  = bus.divresp_rdy;
        if (bus.divresp_rdy) begin
          if (bus.divreq_val) begin
            load    = 1'b1;
            state_d = special ? DONE : CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      result <= '0;
    end else if (load) begin
      a_reg  <= a_init;
      b_reg  <= {1'b0, op_b, {WIDTH{1'b0}}};
      cnt    <= cnt_init;
      sign_q <= is_signed & (bus.divreq_msg_a[WIDTH-1] ^ bus.divreq_msg_b[WIDTH-1]);
      sign_r <= is_signed & bus.divreq_msg_a[WIDTH-1];
      if (special) result <= special_res;
    end else if (state == CALC) begin
      a_reg <= a_step;
      cnt   <= cnt - CNT_W'(1);
      if (step_last) result <= calc_res;
    end
  end

  // Ready is held low while reset is asserted
  assign bus.divreq_rdy         = req_rdy & reset;
  assign bus.divresp_val        = resp_val;
  assign bus.divresp_msg_result = result;

endmodule

// File: tb/tb_imuldiv_int_div_iterative_param.sv
// Self-checking bench for the iterative divider: directed table, corner
// sequences (backpressure, back-to-back, mid-operation reset) and random
// vectors against an arithmetic reference, on WIDTH=32 and WIDTH=8 instances.
module tb_imuldiv_int_div_iterative_param;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imuldiv_int_div_iterative_param_if #(.WIDTH(32)) bus32 ();
  imuldiv_int_div_iterative_param_if #(.WIDTH(8))  bus8  ();

  imuldiv_int_div_iterative_param #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  imuldiv_int_div_iterative_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          sel;
    bit          fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sext(input int w, input logic [63:0] v);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: RISC-V division semantics with plain integer arithmetic
  function automatic logic [63:0] ref_div(input int w, input bit fn,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b, q, r;
    longint sa, sb;
    mask = mask_of(w);
    a = a_in & mask;
    b = b_in & mask;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (fn) begin
      sa = sext(w, a);
      sb = sext(w, b);
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
    return (r << w) | q;
  endfunction

  // Expected cycles from request transfer to response valid
  function automatic int lat_model(input int w, input bit fn,
                                   input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] mask, a, b;
    mask = mask_of(w);
    a = a_in & mask;
    b = b_in & mask;
    if (b == 0) return 1;
    if (fn && a == (64'd1 << (w - 1)) && b == mask) return 1;
`ifdef IMULDIV_DIV_EARLY_OUT_EN
    begin
      logic [63:0] opa;
      int bits;
      opa = (fn && a[w-1]) ? ((-a) & mask) : a;
      if (opa == 0) return 1;
      bits = 0;
      while (opa != 0) begin
        bits++;
        opa = opa >> 1;
      end
      return 1 + bits;
    end
`else
    return w + 1;
`endif
  endfunction

  task automatic drive_req(input int sel, input bit v, input bit fn,
                           input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      bus32.divreq_val    = v;
      bus32.divreq_msg_fn = fn;
      bus32.divreq_msg_a  = a;
      bus32.divreq_msg_b  = b;
    end else begin
      bus8.divreq_val    = v;
      bus8.divreq_msg_fn = fn;
      bus8.divreq_msg_a  = a[7:0];
      bus8.divreq_msg_b  = b[7:0];
    end
  endtask

  task automatic drive_resp_rdy(input int sel, input bit r);
    if (sel == 0) bus32.divresp_rdy = r;
    else          bus8.divresp_rdy  = r;
  endtask

  function automatic bit get_req_rdy(input int sel);
    return (sel == 0) ? bus32.divreq_rdy : bus8.divreq_rdy;
  endfunction

  function automatic bit get_resp_val(input int sel);
    return (sel == 0) ? bus32.divresp_val : bus8.divresp_val;
  endfunction

  function automatic logic [63:0] get_res(input int sel);
    return (sel == 0) ? bus32.divresp_msg_result : {48'd0, bus8.divresp_msg_result};
  endfunction

  // Waits (bounded) for divresp_val; call at the negedge after the transfer edge
  task automatic wait_resp(input int sel, output int lat);
    lat = 1;
    while (!get_resp_val(sel) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One full transaction with latency and result checks
  task automatic run_div(input int sel, input bit fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input string name);
    int w, n, lat;
    w = (sel == 0) ? 32 : 8;
    @(negedge clk);
    drive_req(sel, 1'b1, fn, a, b);
    drive_resp_rdy(sel, 1'b0);
    n = 0;
    while (!get_req_rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check({name, "_req_timeout"}, 64'(get_req_rdy(sel)), 64'd1);
      drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Operands wiggled after the transfer must be ignored
    drive_req(sel, 1'b0, 1'($urandom), $urandom, $urandom);
    wait_resp(sel, lat);
    check({name, "_lat"}, 64'(lat), 64'(lat_model(w, fn, 64'(a), 64'(b))));
    check({name, "_res"}, get_res(sel), exp);
    drive_resp_rdy(sel, 1'b1);
    @(negedge clk);
    drive_resp_rdy(sel, 1'b0);
    check({name, "_idle"}, 64'(get_resp_val(sel)), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] held;

    vt[0] = '{0, 1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, "u100_7"};
    vt[1] = '{0, 1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, "sm100_7"};
    vt[2] = '{0, 1'b1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, "s100_m7"};
    vt[3] = '{0, 1'b1, 32'd5,          32'd0,          64'h00000005_FFFFFFFF, "s5_0"};
    vt[4] = '{0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, "sovf32"};
    vt[5] = '{0, 1'b0, 32'd7,          32'd0,          64'h00000007_FFFFFFFF, "u7_0"};
    vt[6] = '{0, 1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, "umax_1"};
    vt[7] = '{1, 1'b0, 32'd200,        32'd3,          64'h0000000000000242,  "w8_u200_3"};
    vt[8] = '{1, 1'b1, 32'h80,         32'hFF,         64'h0000000000000080,  "w8_sovf"};
    vt[9] = '{1, 1'b1, 32'h9C,         32'd7,          64'h000000000000FEF2,  "w8_sm100_7"};

    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_resp_rdy(0, 1'b0);
    drive_resp_rdy(1, 1'b0);

    // Reset state
    @(negedge clk);
    check("rst_req_rdy32",  64'(bus32.divreq_rdy), 64'd0);
    check("rst_resp_val32", 64'(bus32.divresp_val), 64'd0);
    check("rst_res32",      bus32.divresp_msg_result, 64'd0);
    check("rst_req_rdy8",   64'(bus8.divreq_rdy), 64'd0);
    check("rst_res8",       64'(bus8.divresp_msg_result), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_req_rdy32",  64'(bus32.divreq_rdy), 64'd1);
    check("rel_req_rdy8",   64'(bus8.divreq_rdy), 64'd1);

    // Directed table
    for (int i = 0; i < 10; i++)
      run_div(vt[i].sel, vt[i].fn, vt[i].a, vt[i].b, vt[i].exp, vt[i].name);

    // Backpressure for 10 cycles, then response and new request in one cycle
    @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 32'd100, 32'd7);
    @(posedge clk);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_resp(0, lat);
    check("bp_first_res", bus32.divresp_msg_result, 64'h00000002_0000000E);
    held = bus32.divresp_msg_result;
    for (int i = 0; i < 10; i++) begin
      drive_req(0, 1'b0, 1'b1, $urandom, $urandom);
      @(negedge clk);
      check("bp_hold_val", 64'(bus32.divresp_val), 64'd1);
      check("bp_hold_res", bus32.divresp_msg_result, 64'h00000002_0000000E);
    end
    drive_resp_rdy(0, 1'b1);
    drive_req(0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1);
    #1;
    check("b2b_req_rdy", 64'(bus32.divreq_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    drive_resp_rdy(0, 1'b0);
    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_resp(0, lat);
    check("b2b_lat", 64'(lat), 64'(lat_model(32, 1'b0, 64'hFFFFFFFF, 64'd1)));
    check("b2b_res", bus32.divresp_msg_result, 64'h00000000_FFFFFFFF);
    drive_resp_rdy(0, 1'b1);
    @(negedge clk);
    drive_resp_rdy(0, 1'b0);

    // Reset pulse mid-calculation
    drive_req(0, 1'b1, 1'b0, 32'hFFFF0000, 32'd3);
    @(posedge clk);
    @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_val",   64'(bus32.divresp_val), 64'd0);
    check("midrst_res",   bus32.divresp_msg_result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("postrst_rdy",  64'(bus32.divreq_rdy), 64'd1);
    check("postrst_val",  64'(bus32.divresp_val), 64'd0);
    check("postrst_res",  bus32.divresp_msg_result, 64'd0);
    run_div(0, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after_rst_9_3");

    // Random vectors against the reference model
    for (int i = 0; i < 40; i++) begin
      bit fn;
      logic [31:0] a, b;
      int r;
      fn = 1'($urandom_range(0, 1));
      a  = $urandom >> $urandom_range(0, 31);
      r  = $urandom_range(0, 9);
      if (r == 0)      b = 32'd0;
      else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; fn = 1'b1; end
      else if (r <= 4) b = 32'($urandom_range(1, 15));
      else             b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = -a;
      run_div(0, fn, a, b, ref_div(32, fn, 64'(a), 64'(b)), "rnd32");
    end
    for (int i = 0; i < 30; i++) begin
      bit fn;
      logic [31:0] a, b;
      fn = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 255));
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
      run_div(1, fn, a, b, ref_div(8, fn, 64'(a), 64'(b)), "rnd8");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
